// File: rtl/token_inject_arbiter.sv
// Round-robin scheduler that injects one 4-phase token per grant into a
// self-timed pipeline stage, with ACK synchronizer, token counter and handshake timeout.
module token_inject_arbiter #(
  parameter int NREQ        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TMO_W       = 8,
  parameter int CNT_W       = 16
) (
  input  logic             CP,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [NREQ-1:0]  REQ,
  output logic [NREQ-1:0]  GNT,
  output logic [NREQ-1:0]  DONE,
  output logic             SEND,
  input  logic             ACK,
  output logic             LOPEN,
  input  logic             CLR_ERR,
  output logic             ERR,
  output logic [CNT_W-1:0] TOKCNT
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NREQ-1:0]  GNT_ONE  = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RISE  = 2'd1,
    S_FALL  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          gidx_q, gidx_d;
  logic [NREQ-1:0]        gnt_q, gnt_d;
  logic [NREQ-1:0]        done_q, done_d;
  logic                   send_q, send_d;
  logic                   err_q, err_d;
  logic                   lopen_q, lopen_d;
  logic [CNT_W-1:0]       tokcnt_q, tokcnt_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;

  logic          ack_s;
  logic          start_s;
  logic          tmo_hit_s;
  logic [PW-1:0] pick_idx_s;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    s = (s >= NREQ) ? (s - NREQ) : s;
    return PW'(s);
  endfunction

  assign ack_s     = ack_sync_q[SYNC_STAGES-1];
  assign start_s   = ENABLE & (|REQ) & ~ack_s;
  // The phase times out at the edge where the counter would become all-ones.
  assign tmo_hit_s = (tmo_q == TMO_LAST);

  // Round-robin pick: scanning from the far end lets the nearest request win.
  always_comb begin
    pick_idx_s = ptr_q;
    for (int i = NREQ - 1; i >= 0; i--) begin
      pick_idx_s = REQ[wrap_idx(ptr_q, i)] ? wrap_idx(ptr_q, i) : pick_idx_s;
    end
  end

  // State register plus all registered outputs and the ACK synchronizer.
  always_ff @(posedge CP or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      ack_sync_q <= '0;
      ptr_q      <= '0;
      gidx_q     <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      send_q     <= 1'b0;
      err_q      <= 1'b0;
      lopen_q    <= 1'b0;
      tokcnt_q   <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ACK};
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      send_q     <= send_d;
      err_q      <= err_d;
      lopen_q    <= lopen_d;
      tokcnt_q   <= tokcnt_d;
      tmo_q      <= tmo_d;
    end
  end

  // Next-state logic; completion of a phase takes priority over its timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) state_d = S_RISE;
        else         state_d = S_IDLE;
      end
      S_RISE: begin
        if (ack_s)          state_d = S_FALL;
        else if (tmo_hit_s) state_d = S_ERROR;
        else                state_d = S_RISE;
      end
      S_FALL: begin
        if (!ack_s)         state_d = S_IDLE;
        else if (tmo_hit_s) state_d = S_ERROR;
        else                state_d = S_FALL;
      end
      S_ERROR: begin
        if (CLR_ERR && !ack_s) state_d = S_IDLE;
        else                   state_d = S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values for the registered outputs.
  always_comb begin
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    send_d   = send_q;
    err_d    = err_q;
    tokcnt_d = tokcnt_q;
    tmo_d    = tmo_q;
    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (start_s) begin
          gidx_d = pick_idx_s;
          gnt_d  = GNT_ONE << pick_idx_s;
          send_d = 1'b1;
        end else begin
          gnt_d  = '0;
          send_d = 1'b0;
        end
      end
      S_RISE: begin
        if (ack_s) begin
          send_d = 1'b0;
          tmo_d  = '0;
        end else if (tmo_hit_s) begin
          send_d = 1'b0;
          gnt_d  = '0;
          err_d  = 1'b1;
          ptr_d  = wrap_idx(gidx_q, 1);
        end else begin
          tmo_d  = tmo_q + TMO_ONE;
        end
      end
      S_FALL: begin
        if (!ack_s) begin
          done_d   = gnt_q;
          gnt_d    = '0;
          tokcnt_d = tokcnt_q + CNT_ONE;
          ptr_d    = wrap_idx(gidx_q, 1);
        end else if (tmo_hit_s) begin
          send_d = 1'b0;
          gnt_d  = '0;
          err_d  = 1'b1;
          ptr_d  = wrap_idx(gidx_q, 1);
        end else begin
          tmo_d  = tmo_q + TMO_ONE;
        end
      end
      S_ERROR: begin
        send_d = 1'b0;
        gnt_d  = '0;
        if (CLR_ERR && !ack_s) err_d = 1'b0;
        else                   err_d = 1'b1;
      end
      default: begin
        send_d = 1'b0;
        gnt_d  = '0;
        tmo_d  = '0;
      end
    endcase
    lopen_d = ENABLE & ~err_d;
  end

  assign GNT    = gnt_q;
  assign DONE   = done_q;
  assign SEND   = send_q;
  assign ERR    = err_q;
  assign LOPEN  = lopen_q;
  assign TOKCNT = tokcnt_q;

endmodule

// File: tb/tb_token_inject_arbiter.sv
// Directed bench for token_inject_arbiter (NREQ=4, SYNC_STAGES=2, TMO_W=4, CNT_W=4)
// with a stage model whose ACK follows SEND three cycles later.
module tb_token_inject_arbiter;

  logic       CP = 1'b0;
  logic       RESET;
  logic       ENABLE;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic [3:0] DONE;
  logic       SEND;
  logic       ACK;
  logic       LOPEN;
  logic       CLR_ERR;
  logic       ERR;
  logic [3:0] TOKCNT;

  logic       ack_auto;
  logic       ack_man;
  logic [2:0] ack_dly = 3'b000;

  int checks = 0;
  int errors = 0;

  token_inject_arbiter #(
    .NREQ(4), .SYNC_STAGES(2), .TMO_W(4), .CNT_W(4)
  ) dut (
    .CP(CP), .RESET(RESET), .ENABLE(ENABLE), .REQ(REQ), .GNT(GNT),
    .DONE(DONE), .SEND(SEND), .ACK(ACK), .LOPEN(LOPEN),
    .CLR_ERR(CLR_ERR), .ERR(ERR), .TOKCNT(TOKCNT)
  );

  always #5 CP = ~CP;

  // Stage model: ACK mirrors SEND delayed by three clock cycles.
  always @(posedge CP) ack_dly <= {ack_dly[1:0], SEND};
  assign ACK = ack_auto ? ack_dly[2] : ack_man;

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction from IDLE: grant on the next edge, DONE 12 cycles later.
  task automatic run_txn(input logic [3:0] exp_g, input logic [3:0] exp_cnt, input bit drop);
    int n;
    tick();
    chk("grant", GNT, exp_g);
    chk("send_rise", SEND, 1'b1);
    if (drop) REQ = 4'b0000;
    n = 0;
    while (DONE == 4'b0000 && n < 40) begin
      tick();
      n++;
      chk("gnt_onehot0", $onehot0(GNT), 1'b1);
    end
    chk("done", DONE, exp_g);
    chk("latency", n, 12);
    chk("tokcnt", TOKCNT, exp_cnt);
    chk("gnt_clear", GNT, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] eg;
    RESET = 1'b1; ENABLE = 1'b0; REQ = 4'b0000; CLR_ERR = 1'b0;
    ack_auto = 1'b1; ack_man = 1'b0;
    #1;
    chk("rst_gnt", GNT, 4'b0000);
    chk("rst_send", SEND, 1'b0);
    chk("rst_done", DONE, 4'b0000);
    chk("rst_err", ERR, 1'b0);
    chk("rst_lopen", LOPEN, 1'b0);
    chk("rst_tokcnt", TOKCNT, 4'd0);
    repeat (2) tick();
    RESET = 1'b0;

    // Single request
    ENABLE = 1'b1; REQ = 4'b0001;
    run_txn(4'b0001, 4'd1, 1'b0);
    chk("single_lopen", LOPEN, 1'b1);
    REQ = 4'b0000;
    tick();
    chk("single_done_pulse", DONE, 4'b0000);
    chk("single_gnt_idle", GNT, 4'b0000);
    chk("single_tokcnt", TOKCNT, 4'd1);

    // Round robin from a fresh pointer, 17 transactions wrap the 4-bit counter
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    REQ = 4'b1111;
    for (int k = 0; k < 17; k++) begin
      eg = 4'b0001 << (k % 4);
      run_txn(eg, 4'((k + 1) % 16), 1'b0);
    end
    chk("wrap_tokcnt", TOKCNT, 4'd1);

    // Request dropped during RISE still completes; pointer is at 1
    REQ = 4'b0100;
    run_txn(4'b0100, 4'd2, 1'b1);

    // Timeout in RISE with ACK held low; pointer is at 3
    ack_auto = 1'b0; ack_man = 1'b0; REQ = 4'b0001;
    tick();
    chk("tmo_grant", GNT, 4'b0001);
    repeat (14) tick();
    chk("tmo_send_hold", SEND, 1'b1);
    chk("tmo_err_pre", ERR, 1'b0);
    tick();
    chk("tmo_send", SEND, 1'b0);
    chk("tmo_err", ERR, 1'b1);
    chk("tmo_lopen", LOPEN, 1'b0);
    chk("tmo_gnt", GNT, 4'b0000);
    chk("tmo_done", DONE, 4'b0000);
    chk("tmo_tokcnt", TOKCNT, 4'd2);
    REQ = 4'b0011;
    repeat (3) tick();
    chk("err_hold", ERR, 1'b1);
    chk("err_no_gnt", GNT, 4'b0000);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    chk("clr_err", ERR, 1'b0);
    chk("clr_lopen", LOPEN, 1'b1);
    ack_auto = 1'b1;
    run_txn(4'b0010, 4'd3, 1'b0);

    // Stuck ACK at idle blocks grants; pointer is at 2
    ack_auto = 1'b0; ack_man = 1'b1; REQ = 4'b0000;
    repeat (2) tick();
    REQ = 4'b0001;
    repeat (4) begin
      tick();
      chk("stuck_no_gnt", GNT, 4'b0000);
      chk("stuck_no_send", SEND, 1'b0);
    end
    ack_man = 1'b0;
    repeat (2) begin
      tick();
      chk("stuck_sync_gnt", GNT, 4'b0000);
    end
    ack_auto = 1'b1;
    run_txn(4'b0001, 4'd4, 1'b0);

    // Reset in FALL while ACK is high
    tick();
    chk("fall_grant", GNT, 4'b0001);
    repeat (6) tick();
    chk("fall_send", SEND, 1'b0);
    ack_auto = 1'b0; ack_man = 1'b1;
    RESET = 1'b1;
    #1;
    chk("mid_rst_gnt", GNT, 4'b0000);
    chk("mid_rst_send", SEND, 1'b0);
    chk("mid_rst_done", DONE, 4'b0000);
    chk("mid_rst_err", ERR, 1'b0);
    chk("mid_rst_lopen", LOPEN, 1'b0);
    chk("mid_rst_tokcnt", TOKCNT, 4'd0);
    REQ = 4'b0000;
    repeat (2) tick();
    RESET = 1'b0;
    repeat (2) tick();
    REQ = 4'b0001;
    repeat (3) begin
      tick();
      chk("post_rst_no_gnt", GNT, 4'b0000);
    end
    ack_man = 1'b0;
    repeat (2) tick();
    ack_auto = 1'b1;
    run_txn(4'b0001, 4'd1, 1'b0);

    // ENABLE low blocks grants; dropping it mid-transaction does not abort
    ENABLE = 1'b0; REQ = 4'b0010;
    tick();
    chk("dis_lopen", LOPEN, 1'b0);
    repeat (2) tick();
    chk("dis_no_gnt", GNT, 4'b0000);
    ENABLE = 1'b1;
    tick();
    chk("en_grant", GNT, 4'b0010);
    chk("en_lopen", LOPEN, 1'b1);
    ENABLE = 1'b0;
    repeat (12) tick();
    chk("dis_mid_done", DONE, 4'b0010);
    chk("dis_mid_tokcnt", TOKCNT, 4'd2);
    tick();
    chk("dis_after_gnt", GNT, 4'b0000);
    chk("dis_after_done", DONE, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/token_inject_arbiter.md
Name: token_inject_arbiter

Overview:
- Clocked scheduler sharing the input handshake of a self-timed C-element pipeline stage between NREQ synchronous requesters.
- Round-robin arbitration; runs one 4-phase (return-to-zero) token injection per grant: drives the stage SEND input and samples its asynchronous ACK through a synchronizer.
- Also drives the stage latch-open control (LOPEN), counts injected tokens and aborts hung handshakes with a timeout.
- Sits between the synchronous control logic and the asynchronous token ring.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SYNC_STAGES, 2, flip-flops in the ACK synchronizer (2..3).
- TMO_W, 8, width of the handshake timeout counter; timeout = 2^TMO_W-1 cycles per phase.
- CNT_W, 16, width of the injected-token counter.

Ports:
- CP  input  1  clock.
- RESET  input  1  asynchronous, active-high reset.
- ENABLE  input  1  permits new grants; when low, no new transaction starts.
- REQ  input  NREQ  per-requester request, level; held until matching DONE.
- GNT  output  NREQ  one-hot grant, high for the whole transaction.
- DONE  output  NREQ  one-cycle pulse on the granted bit when the handshake completes.
- SEND  output  1  request to pipeline stage input (registered, glitch-free).
- ACK  input  1  acknowledge from pipeline stage, asynchronous to CP.
- LOPEN  output  1  latch-open control to the stage.
- CLR_ERR  input  1  pulse; leaves ERROR state.
- ERR  output  1  sticky timeout flag.
- TOKCNT  output  CNT_W  completed-injection count.

Behaviour:
- Reset (async assert, sync release): state=IDLE, SEND=0, GNT=0, DONE=0, ERR=0, LOPEN=0, TOKCNT=0, rr pointer=0, sync chain=0.
- ACK_s is ACK after SYNC_STAGES flops; only ACK_s is used by the logic.
- LOPEN is registered: LOPEN <= ENABLE & ~ERR.
- States: IDLE, RISE, FALL, ERROR.
- IDLE:
  - If ENABLE & |REQ & ~ACK_s: choose the first set REQ at or after the pointer, wrapping modulo NREQ.
  - At that edge: GNT <= onehot(g), SEND <= 1, timeout <= 0, go to RISE.
  - If ACK_s=1 in IDLE, wait; no grant is issued.
- RISE:
  - SEND=1; timeout increments each cycle.
  - When ACK_s=1: SEND <= 0, timeout <= 0, go to FALL.
- FALL:
  - SEND=0; timeout increments.
  - When ACK_s=0: DONE[g] <= 1 for one cycle, GNT <= 0, TOKCNT <= TOKCNT+1 (wraps at 2^CNT_W), pointer <= (g+1) mod NREQ, go to IDLE.
- Timeout: if the counter reaches all-ones in RISE or FALL, go to ERROR at the same edge.
  - Actions at that edge: SEND <= 0, GNT <= 0, ERR <= 1, LOPEN <= 0, no DONE, TOKCNT unchanged.
  - The pointer advances past g so a hung requester cannot starve the others.
- ERROR: stays until CLR_ERR=1 & ACK_s=0, then ERR <= 0 and go to IDLE. CLR_ERR in any other state is ignored.
- Mid-transaction changes:
  - REQ[g] dropping mid-transaction is ignored; the handshake completes and DONE still pulses.
  - ENABLE low mid-transaction does not abort the transaction; it only blocks the next grant and drops LOPEN.
- Latency with immediate ACK response: SEND rises 1 cycle after REQ is sampled. SEND falls SYNC_STAGES+1 cycles after the ACK rise edge, then DONE follows the ACK fall by SYNC_STAGES+1 cycles.
- Back-to-back: the next grant is possible the cycle after DONE, because IDLE is entered with ACK_s=0.
- Invariants: SEND never toggles twice without an intervening ACK_s edge; GNT is zero or one-hot; DONE implies GNT was set in the preceding cycle.

Test Plan:
- Single request, SYNC_STAGES=2: REQ=0001; ACK model follows SEND after 3 cycles -> GNT=0001, SEND high 1 cycle after REQ, one DONE=0001 pulse, TOKCNT=1, GNT=0 afterwards.
- Round-robin: REQ=1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3; TOKCNT=8; GNT always one-hot.
- Timeout, TMO_W=4: ACK held 0 -> after 15 cycles in RISE: SEND=0, ERR=1, LOPEN=0, no DONE. CLR_ERR with ACK=0 -> ERR=0, next grant goes to requester g+1.
- Stuck ACK: ACK=1 at idle with REQ=0001 -> no grant until ACK falls, then a normal transaction.
- Reset mid-FALL: assert RESET while SEND=0 and ACK=1 -> all outputs 0 immediately. After release, no grant until ACK_s=0.
- Counter wrap, CNT_W=4: 17 transactions -> TOKCNT=1. REQ dropped during RISE -> transaction completes and DONE still pulses.
